rns_to_int_mrc: RTL and testbench

//  Reverse converter placed directly downstream of the RNS FIR filter. Accepts one 32-bit packed RNS word
//  (moduli 233/239/241/251) and returns the 32-bit two's-complement integer. Uses sequential mixed-radix

---
 rtl/rns_to_int_mrc_pkg.sv | 110 +++++++++++
 rtl/rns_to_int_mrc_if.sv | 20 ++
 rtl/rns_mrc_digit.sv | 17 +
 rtl/rns_to_int_mrc.sv | 136 +++++++++++++
 tb/tb_rns_to_int_mrc.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rns_to_int_mrc_pkg.sv
// Shared RNS definitions: moduli, lane layout, MRC inverses, weights and lane arithmetic.
package rns_to_int_mrc_pkg;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ACC_W     = 34;
    localparam int unsigned NUM_LANES = 4;

    localparam int unsigned OFF1 = 0;
    localparam int unsigned OFF2 = 8;
    localparam int unsigned OFF3 = 16;
    localparam int unsigned OFF4 = 24;

    localparam logic [LANE_W-1:0] MOD1 = 8'd233;
    localparam logic [LANE_W-1:0] MOD2 = 8'd239;
    localparam logic [LANE_W-1:0] MOD3 = 8'd241;
    localparam logic [LANE_W-1:0] MOD4 = 8'd251;

    // inv(mi) mod mj used by the mixed-radix digit chain
    localparam logic [LANE_W-1:0] INV12 = 8'd199;
    localparam logic [LANE_W-1:0] INV13 = 8'd30;
    localparam logic [LANE_W-1:0] INV14 = 8'd237;
    localparam logic [LANE_W-1:0] INV23 = 8'd120;
    localparam logic [LANE_W-1:0] INV24 = 8'd230;
    localparam logic [LANE_W-1:0] INV34 = 8'd25;

    localparam logic [ACC_W-1:0] W1     = 34'd1;
    localparam logic [ACC_W-1:0] W2     = 34'd233;
    localparam logic [ACC_W-1:0] W3     = 34'd55687;
    localparam logic [ACC_W-1:0] W4     = 34'd13420567;
    localparam logic [ACC_W-1:0] M_VAL  = 34'd3368562317;
    localparam logic [ACC_W-1:0] M_HALF = 34'd1684281159;

    typedef struct packed {
        logic [LANE_W-1:0] r4;
        logic [LANE_W-1:0] r3;
        logic [LANE_W-1:0] r2;
        logic [LANE_W-1:0] r1;
    } rns_word_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_D2   = 3'd1,
        S_D3   = 3'd2,
        S_D4   = 3'd3,
        S_ACC  = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    function automatic logic [LANE_W-1:0] lane_mod(input int unsigned idx);
        case (idx)
            0:       return MOD1;
            1:       return MOD2;
            2:       return MOD3;
            default: return MOD4;
        endcase
    endfunction

    function automatic logic [LANE_W-1:0] sub_mod(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b,
                                                  input logic [LANE_W-1:0] m);
        logic [LANE_W:0] t;
        t = (a >= b) ? (9'(a) - 9'(b)) : (9'(a) + 9'(m) - 9'(b));
        return 8'(t);
    endfunction

    function automatic logic [LANE_W-1:0] add_mod(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b,
                                                  input logic [LANE_W-1:0] m);
        logic [LANE_W:0] s;
        s = 9'(a) + 9'(b);
        return (s >= 9'(m)) ? 8'(s - 9'(m)) : 8'(s);
    endfunction

    function automatic logic [LANE_W-1:0] mul_mod(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b,
                                                  input logic [LANE_W-1:0] m);
        logic [2*LANE_W-1:0] p;
        p = 16'(a) * 16'(b);
        return 8'(p % 16'(m));
    endfunction

    function automatic logic [WORD_W-1:0] rns_add(input logic [WORD_W-1:0] x,
                                                  input logic [WORD_W-1:0] y);
        logic [WORD_W-1:0] z;
        z = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
            z[i*LANE_W +: LANE_W] = add_mod(x[i*LANE_W +: LANE_W], y[i*LANE_W +: LANE_W], lane_mod(i));
        return z;
    endfunction

    function automatic logic [WORD_W-1:0] rns_sub(input logic [WORD_W-1:0] x,
                                                  input logic [WORD_W-1:0] y);
        logic [WORD_W-1:0] z;
        z = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
            z[i*LANE_W +: LANE_W] = sub_mod(x[i*LANE_W +: LANE_W], y[i*LANE_W +: LANE_W], lane_mod(i));
        return z;
    endfunction

    function automatic logic [WORD_W-1:0] rns_mul(input logic [WORD_W-1:0] x,
                                                  input logic [WORD_W-1:0] y);
        logic [WORD_W-1:0] z;
        z = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++)
            z[i*LANE_W +: LANE_W] = mul_mod(x[i*LANE_W +: LANE_W], y[i*LANE_W +: LANE_W], lane_mod(i));
        return z;
    endfunction

endpackage

// File: rtl/rns_to_int_mrc_if.sv
// Input/output handshake bundle of the RNS reverse converter.
interface rns_to_int_mrc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rns;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        out_err;

    modport slave (
        input  in_valid, in_rns, out_ready,
        output in_ready, out_valid, y, out_err
    );

    modport master (
        output in_valid, in_rns, out_ready,
        input  in_ready, out_valid, y, out_err
    );
endinterface

// File: rtl/rns_mrc_digit.sv
// One mixed-radix step: (r - a) * inv mod m, all operands below m.
module rns_mrc_digit
    import rns_to_int_mrc_pkg::*;
(
    input  logic [7:0] r,
    input  logic [7:0] a,
    input  logic [7:0] inv,
    input  logic [7:0] m,
    output logic [7:0] d
);

    // Subtract then scale, both reduced mod m.
    always_comb begin
        d = mul_mod(sub_mod(r, a, m), inv, m);
    end

endmodule

// File: rtl/rns_to_int_mrc.sv
// Sequential MRC reverse converter: one mixed-radix digit per state, then weighted accumulation.
module rns_to_int_mrc
    import rns_to_int_mrc_pkg::*;
#(
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    rns_to_int_mrc_if.slave   bus
);

    state_t      state;
    state_t      state_next;
    logic        in_ready_next;
    logic        out_valid_next;

    logic [7:0]  r2_q, r3_q, r4_q;
    logic [7:0]  a1_q, a2_q, a3_q, a4_q;
    logic        err_q;
    logic [31:0] y_q;
    logic        out_err_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [7:0]  d_r, d_inv0, d_inv1, d_m;
    logic [7:0]  d0, d1, d2;
    logic [ACC_W-1:0] x_acc;
    logic [31:0] y_next;
    logic        lane_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.in_valid) state_next = S_D2;
            S_D2:    state_next = S_D3;
            S_D3:    state_next = S_D4;
            S_D4:    state_next = S_ACC;
            S_ACC:   state_next = S_OUT;
            S_OUT:   if (bus.out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        in_ready_next  = (state_next == S_IDLE);
        out_valid_next = (state_next == S_OUT);
    end

    // Route the lane residue, inverses and modulus for the digit being produced.
    always_comb begin
        d_r    = r2_q;
        d_inv0 = INV12;
        d_inv1 = INV23;
        d_m    = MOD2;
        case (state)
            S_D3: begin
                d_r    = r3_q;
                d_inv0 = INV13;
                d_inv1 = INV23;
                d_m    = MOD3;
            end
            S_D4: begin
                d_r    = r4_q;
                d_inv0 = INV14;
                d_inv1 = INV24;
                d_m    = MOD4;
            end
            default: ;
        endcase
    end

    rns_mrc_digit u_dig0 (.r(d_r), .a(a1_q), .inv(d_inv0), .m(d_m), .d(d0));
    rns_mrc_digit u_dig1 (.r(d0),  .a(a2_q), .inv(d_inv1), .m(d_m), .d(d1));
    rns_mrc_digit u_dig2 (.r(d1),  .a(a3_q), .inv(INV34),  .m(d_m), .d(d2));

    // Weighted sum of digits and optional signed folding around M/2.
    always_comb begin
        x_acc = 34'(a1_q) * W1 + 34'(a2_q) * W2 + 34'(a3_q) * W3 + 34'(a4_q) * W4;
        if (err_q)
            y_next = '0;
        else if (SIGNED_OUT && (x_acc >= M_HALF))
            y_next = 32'(x_acc - M_VAL);
        else
            y_next = 32'(x_acc);
        lane_err = (bus.in_rns[OFF1 +: 8] >= MOD1) || (bus.in_rns[OFF2 +: 8] >= MOD2) ||
                   (bus.in_rns[OFF3 +: 8] >= MOD3) || (bus.in_rns[OFF4 +: 8] >= MOD4);
    end

    // Residue latch, digit registers and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r2_q        <= '0;
            r3_q        <= '0;
            r4_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            err_q       <= 1'b0;
            y_q         <= '0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_next;
            out_valid_q <= out_valid_next;
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    a1_q  <= bus.in_rns[OFF1 +: 8];
                    r2_q  <= bus.in_rns[OFF2 +: 8];
                    r3_q  <= bus.in_rns[OFF3 +: 8];
                    r4_q  <= bus.in_rns[OFF4 +: 8];
                    err_q <= lane_err;
                end
                S_D2:  a2_q <= d0;
                S_D3:  a3_q <= d1;
                S_D4:  a4_q <= d2;
                S_ACC: begin
                    y_q       <= y_next;
                    out_err_q <= err_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_rns_to_int_mrc.sv
// Scoreboard bench: signed and unsigned converters run in lockstep on the same stimulus.
module tb_rns_to_int_mrc;

    localparam longint M_L = 64'd3368562317;

    typedef struct {
        logic [31:0] ys;
        logic [31:0] yu;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;
    int   acc_cyc;
    exp_t sb[$];
    exp_t mon_e;

    rns_to_int_mrc_if s_if ();
    rns_to_int_mrc_if u_if ();

    assign u_if.in_valid  = s_if.in_valid;
    assign u_if.in_rns    = s_if.in_rns;
    assign u_if.out_ready = s_if.out_ready;

    rns_to_int_mrc #(.SIGNED_OUT(1'b1)) u_dut_s (.clk(clk), .reset(reset), .bus(s_if.slave));
    rns_to_int_mrc #(.SIGNED_OUT(1'b0)) u_dut_u (.clk(clk), .reset(reset), .bus(u_if.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_pack(input longint v);
        longint mods [4];
        longint r;
        logic [31:0] w;
        mods = '{233, 239, 241, 251};
        w = '0;
        for (int i = 0; i < 4; i++) begin
            r = v % mods[i];
            if (r < 0) r = r + mods[i];
            w[i*8 +: 8] = 8'(r);
        end
        return w;
    endfunction

    function automatic exp_t exp_of(input longint v);
        exp_t e;
        e.ys  = 32'(v);
        e.yu  = (v < 0) ? 32'(v + M_L) : 32'(v);
        e.err = 1'b0;
        return e;
    endfunction

    function automatic exp_t exp_err();
        exp_t e;
        e.ys  = '0;
        e.yu  = '0;
        e.err = 1'b1;
        return e;
    endfunction

    // Pops and checks every completed output handshake.
    always @(negedge clk) begin
        if (!reset && s_if.out_valid === 1'b1 && s_if.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_output: y=%h with empty scoreboard", s_if.y);
            end else begin
                mon_e = sb.pop_front();
                tests++;
                if (s_if.y !== mon_e.ys) begin
                    fails++;
                    $display("FAIL y_signed: got %h expected %h", s_if.y, mon_e.ys);
                end
                tests++;
                if (u_if.y !== mon_e.yu) begin
                    fails++;
                    $display("FAIL y_unsigned: got %h expected %h", u_if.y, mon_e.yu);
                end
                tests++;
                if (s_if.out_err !== mon_e.err || u_if.out_err !== mon_e.err) begin
                    fails++;
                    $display("FAIL out_err: got %b/%b expected %b", s_if.out_err, u_if.out_err, mon_e.err);
                end
                tests++;
                if (u_if.out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL lockstep_valid: unsigned out_valid %b expected 1", u_if.out_valid);
                end
            end
        end
    end

    // Present a word, wait until it is accepted, and record the expectation.
    task automatic send(input logic [31:0] w, input exp_t e);
        int n;
        n = 0;
        s_if.in_valid = 1'b1;
        s_if.in_rns   = w;
        while (s_if.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready %b expected 1", s_if.in_ready);
            s_if.in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            acc_cyc = cyc;
            @(posedge clk); #1;
            s_if.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        s_if.in_valid  = 1'b0;
        s_if.in_rns    = '0;
        s_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (s_if.in_ready !== 1'b1 || s_if.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", s_if.in_ready, s_if.out_valid);
        end
        tests++;
        if (s_if.y !== 32'h0 || s_if.out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: y=%h out_err=%b expected 0/0", s_if.y, s_if.out_err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // out_valid is seen after the 4th edge following the accept edge (5th counting the accept).
    task automatic test_basic();
        int n;
        s_if.out_ready = 1'b1;
        send(32'h01010101, exp_of(1));
        n = 0;
        while (s_if.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != 4) begin
            fails++;
            $display("FAIL latency: out_valid after %0d edges past accept, expected 4", n);
        end
        wait_drain();
    endtask

    task automatic test_values();
        s_if.out_ready = 1'b1;
        send(32'hFAF0EEE8, exp_of(-1));
        send(32'hF7242C44, exp_of(1000));
        send(32'h0C0C0C0C, exp_of(12));
        send(32'h00000000, exp_of(0));
        send(model_pack(64'sd1684281158), exp_of(64'sd1684281158));
        send(model_pack(-64'sd1684281158), exp_of(-64'sd1684281158));
        send(model_pack(-64'sd1000), exp_of(-64'sd1000));
        wait_drain();
    endtask

    task automatic test_err();
        s_if.out_ready = 1'b1;
        send(32'h000000E9, exp_err());
        send(32'h01010101, exp_of(1));
        send(32'hFB000000, exp_err());
        send(32'h00F10000, exp_err());
        send(32'h0C0C0C0C, exp_of(12));
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int prev;
        s_if.out_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            send(model_pack(longint'(k * 7919 - 20000)), exp_of(longint'(k * 7919 - 20000)));
            s_if.in_valid = 1'b1;
            if (k > 0) begin
                tests++;
                if (acc_cyc - prev != 6) begin
                    fails++;
                    $display("FAIL issue_period: %0d cycles between accepts, expected 6", acc_cyc - prev);
                end
            end
            prev = acc_cyc;
        end
        s_if.in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] hold_y;
        logic stable;
        s_if.out_ready = 1'b0;
        send(32'h0C0C0C0C, exp_of(12));
        n = 0;
        while (s_if.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        hold_y = s_if.y;
        s_if.in_valid = 1'b1;
        s_if.in_rns   = 32'hF7242C44;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (s_if.y !== hold_y || s_if.out_valid !== 1'b1 || s_if.in_ready !== 1'b0) stable = 1'b0;
        end
        tests++;
        if (!stable || hold_y !== 32'd12) begin
            fails++;
            $display("FAIL stall_hold: y=%h valid=%b in_ready=%b expected y=0000000c held, valid 1, in_ready 0",
                     s_if.y, s_if.out_valid, s_if.in_ready);
        end
        s_if.out_ready = 1'b1;
        sb.push_back(exp_of(1000));
        @(posedge clk); #1;
        tests++;
        if (s_if.in_ready !== 1'b1 || s_if.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b expected 1/0", s_if.in_ready, s_if.out_valid);
        end
        @(posedge clk); #1;
        s_if.in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_abort();
        logic seen;
        s_if.out_ready = 1'b1;
        send(32'h0C0C0C0C, exp_of(12));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (s_if.in_ready !== 1'b1 || s_if.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: in_ready=%b out_valid=%b expected 1/0", s_if.in_ready, s_if.out_valid);
        end
        reset = 1'b0;
        sb.delete();
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (s_if.out_valid !== 1'b0 || s_if.y !== 32'h0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL abort_no_output: out_valid=%b y=%h expected 0/0", s_if.out_valid, s_if.y);
        end
        send(32'h01010101, exp_of(1));
        wait_drain();
    endtask

    task automatic test_random();
        int mods [4];
        longint v;
        logic [31:0] w;
        int lane;
        mods = '{233, 239, 241, 251};
        s_if.out_ready = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            v = longint'($urandom_range(32'd3368562316, 32'd0)) - 64'sd1684281158;
            w = model_pack(v);
            if ($urandom_range(15, 0) == 0) begin
                lane = int'($urandom_range(3, 0));
                w[lane*8 +: 8] = 8'(mods[lane] + int'($urandom_range(32'(255 - mods[lane]), 0)));
                send(w, exp_err());
            end else begin
                send(w, exp_of(v));
            end
            s_if.in_valid = 1'b1;
        end
        s_if.in_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        acc_cyc = 0;
        test_reset();
        test_basic();
        test_values();
        test_err();
        test_back_to_back();
        test_stall();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
